div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU. Sits beside the alu in the E stage; the alu returns 0 for these ops.
- Consumes the same operands (a = rs, b = rt) and alucontrolE. Produces the 64-bit {HI,LO} word that is written to the HI/LO register.
- Stalls the pipeline while busy; a flush annuls it.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported. Iteration count equals WIDTH.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  asynchronous active-low reset
- a  input  32  dividend (rs value)
- b  input  32  divisor (rt value)
- alucontrolE  input  5  E-stage ALU control; `DIV_CONTROL / `DIVU_CONTROL from defines2.vh
- flushE  input  1  annul E-stage instruction
- div_result  output  64  {remainder, quotient} = {HI, LO}
- div_ready  output  1  one-cycle pulse; div_result valid
- div_stall  output  1  hold F/D/E stages

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - div_result=64'h0, div_ready=0, div_stall=0.
  - Internal counter and registers cleared.
- Definitions:
  - start = (alucontrolE==`DIV_CONTROL || alucontrolE==`DIVU_CONTROL) && !flushE.
  - signed_op = (alucontrolE==`DIV_CONTROL), latched at start.
- div_stall (combinational):
  - = (state==IDLE && start) || (state==BUSY && !flushE).
  - 0 in DONE.
- Operand handling:
  - Signed op: latch |a| and |b| (two's-complement negate when bit31 set), plus qsign = a[31]^b[31] and rsign = a[31].
  - Unsigned op: latch operands as-is, qsign=rsign=0.
- States:
  - IDLE:
    - start && b!=0 -> BUSY; latch operands; counter=0.
    - start && b==0 -> DONE; result={a, 32'hFFFFFFFF} (divide-by-zero is defined as remainder=a, quotient=all ones, for both signedness).
    - Otherwise stay in IDLE.
  - BUSY:
    - One quotient bit per cycle. The partial remainder is WIDTH+1 bits wide: shift {rem,dividend} left 1, trial-subtract the divisor, keep the result if it is non-negative and set the quotient bit.
    - counter increments each cycle; when counter==WIDTH-1 -> DONE.
    - flushE=1 -> IDLE, no result written.
  - DONE:
    - div_ready=1 for exactly this cycle.
    - div_result register updated on entry to DONE: quotient negated if qsign, remainder negated if rsign.
    - Unconditionally -> IDLE; alucontrolE is ignored in this cycle, because the pipeline advances on the deasserted stall.
- Latency:
  - DIV/DIVU enters E at cycle T (IDLE, stall=1).
  - BUSY occupies T+1..T+32.
  - DONE at T+33: ready=1, stall=0.
  - Total E occupancy: 34 cycles.
  - Divide-by-zero: DONE at T+1.
- div_result holds its last value outside DONE; downstream only samples it while div_ready=1.
- Back-to-back DIVs: a second DIV arriving in E at T+34 (IDLE) starts normally. No lost or duplicated ready.
- Overflow case: 0x80000000 / 0xFFFFFFFF (signed) -> quotient 0x80000000, remainder 0. This falls out of the 32-bit negate wrap; no trap.
- flushE in DONE does not suppress div_ready; flush handling is the consumer's gating responsibility.
- Reset asserted mid-operation -> IDLE immediately, with outputs at their reset values.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if start && b!=0 && |a| < |b| (magnitudes per signedness), go directly to DONE.
  - Result is {a, 32'h0}: remainder keeps a's original sign, quotient 0.
  - Latency is 1 cycle: ready at T+1.
- Undefined: all nonzero-divisor cases take the full 32 BUSY cycles.

Test Plan:
- DIVU a=100, b=7 at T -> div_ready at T+33 with div_result={32'd2, 32'd14}; div_stall=1 during T..T+32 and 0 at T+33.
- DIV a=-7 (0xFFFFFFF9), b=2 -> div_result={32'hFFFFFFFF, 32'hFFFFFFFD}, i.e. remainder -1 and quotient -3.
- DIV a=0x80000000, b=0xFFFFFFFF -> {32'h0, 32'h80000000}. Without DIV_EARLY_OUT_EN, ready at T+33.
- DIVU a=0x1234, b=0 -> ready at T+1, div_result={32'h00001234, 32'hFFFFFFFF}.
- DIVU 100/7, flushE=1 at T+10 -> no div_ready, state IDLE at T+11, div_stall=0. A new DIVU 9/3 at T+12 gives {0, 3} at T+45.
- DIV 5/9 with DIV_EARLY_OUT_EN -> ready at T+1 with {32'd5, 32'd0}. Without the macro -> same value at T+33. resetn pulsed low at T+5 -> outputs 0 immediately, no ready.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU, producing {HI,LO} = {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
`ifndef DIV_CONTROL
`define DIV_CONTROL  5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL 5'b11011
`endif

module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [4:0]         alucontrolE,
  input  logic               flushE,
  output logic [2*WIDTH-1:0] div_result,
  output logic               div_ready,
  output logic               div_stall
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   quo_reg, quo_next;
  logic [WIDTH-1:0]   dvs_reg, dvs_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic               qsign_reg, qsign_next;
  logic               rsign_reg, rsign_next;
  logic [2*WIDTH-1:0] result_reg, result_next;

  logic               start, signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     shifted;
  logic               ge;
  logic [WIDTH-1:0]   step_rem, step_q, fin_q, fin_r;

  assign signed_op = (alucontrolE == `DIV_CONTROL);
  assign start     = ((alucontrolE == `DIV_CONTROL) || (alucontrolE == `DIVU_CONTROL)) && !flushE;
  assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

  // The restored remainder is always below the divisor, so only the shifted
  // trial value needs the extra bit.
  assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, dvs_reg});
  assign step_rem = ge ? (shifted[WIDTH-1:0] - dvs_reg) : shifted[WIDTH-1:0];
  assign step_q   = {quo_reg[WIDTH-2:0], ge};
  assign fin_q    = qsign_reg ? -step_q : step_q;
  assign fin_r    = rsign_reg ? -step_rem : step_rem;

  always_comb begin
    state_next  = state_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    dvs_next    = dvs_reg;
    cnt_next    = cnt_reg;
    qsign_next  = qsign_reg;
    rsign_next  = rsign_reg;
    result_next = result_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (b == '0) begin
            state_next  = DONE;
            result_next = {a, {WIDTH{1'b1}}};
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_a < abs_b) begin
            state_next  = DONE;
            result_next = {a, {WIDTH{1'b0}}};
          end
`endif
          else begin
            state_next = BUSY;
            rem_next   = '0;
            quo_next   = abs_a;
            dvs_next   = abs_b;
            cnt_next   = '0;
            qsign_next = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            rsign_next = signed_op && a[WIDTH-1];
          end
        end
      end
      BUSY: begin
        if (flushE) begin
          state_next = IDLE;
        end else begin
          rem_next = step_rem;
          quo_next = step_q;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CW'(WIDTH-1)) begin
            state_next  = DONE;
            result_next = {fin_r, fin_q};
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      cnt_reg    <= '0;
      qsign_reg  <= 1'b0;
      rsign_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      dvs_reg    <= dvs_next;
      cnt_reg    <= cnt_next;
      qsign_reg  <= qsign_next;
      rsign_reg  <= rsign_next;
      result_reg <= result_next;
    end
  end

  assign div_result = result_reg;
  assign div_ready  = (state_reg == DONE);
  // Gated by resetn so the stall drops the moment reset is asserted.
  assign div_stall  = resetn && (((state_reg == IDLE) && start) || ((state_reg == BUSY) && !flushE));

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors for div_unit with hand-computed quotient/remainder and latency.
`ifndef DIV_CONTROL
`define DIV_CONTROL  5'b11010
`endif
`ifndef DIVU_CONTROL
`define DIVU_CONTROL 5'b11011
`endif

module tb_div_unit;
  localparam logic [4:0] C_DIV  = `DIV_CONTROL;
  localparam logic [4:0] C_DIVU = `DIVU_CONTROL;
  localparam logic [4:0] C_NOP  = 5'b00000;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  alucontrolE = C_NOP;
  logic        flushE = 1'b0;
  logic [63:0] div_result;
  logic        div_ready;
  logic        div_stall;

  int total = 0;
  int bad = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .a(a), .b(b), .alucontrolE(alucontrolE),
    .flushE(flushE), .div_result(div_result), .div_ready(div_ready), .div_stall(div_stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%h", tag, got);
    end
  endtask

  // Issue one op at cycle T, hold it while stalled, and time the ready pulse.
  task automatic run_div(input string tag, input logic [4:0] ctrl, input logic [31:0] av,
                         input logic [31:0] bv, input logic [63:0] exp, input int exp_lat);
    int k;
    int stall_lo;
    @(negedge clk);
    alucontrolE = ctrl; a = av; b = bv;
    #1;
    k = 0;
    stall_lo = 0;
    while (!div_ready && k < 60) begin
      if (!div_stall) stall_lo++;
      @(negedge clk); #1;
      k++;
    end
    check({tag, ".lat"}, 64'(k), 64'(exp_lat));
    check({tag, ".stall_busy"}, 64'(stall_lo), 64'd0);
    check({tag, ".result"}, div_result, exp);
    check({tag, ".stall_done"}, {63'd0, div_stall}, 64'd0);
    alucontrolE = C_NOP;
    @(negedge clk); #1;
    check({tag, ".one_pulse"}, {63'd0, div_ready}, 64'd0);
    check({tag, ".hold"}, div_result, exp);
  endtask

  initial begin
    int rdy_cnt;
    repeat (2) @(negedge clk);
    #1;
    check("rst.result", div_result, 64'd0);
    check("rst.ready", {63'd0, div_ready}, 64'd0);
    check("rst.stall", {63'd0, div_stall}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_div("divu_100_7", C_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    run_div("div_m7_2", C_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div("div_7_m2", C_DIV, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33);
    run_div("div_ovf", C_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
    run_div("divu_max_1", C_DIVU, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33);
    run_div("divu_by0", C_DIVU, 32'h00001234, 32'd0, {32'h00001234, 32'hFFFFFFFF}, 1);
    run_div("div_5_9", C_DIV, 32'd5, 32'd9, {32'd5, 32'd0}, EARLY_LAT);

    // Flush during BUSY at T+10, then a fresh DIVU at T+12.
    @(negedge clk);
    alucontrolE = C_DIVU; a = 32'd100; b = 32'd7;
    rdy_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      if (div_ready) rdy_cnt++;
    end
    flushE = 1'b1;
    #1;
    check("flush.stall", {63'd0, div_stall}, 64'd0);
    @(negedge clk);
    flushE = 1'b0; alucontrolE = C_NOP;
    #1;
    check("flush.ready", {63'd0, div_ready}, 64'd0);
    check("flush.idle_stall", {63'd0, div_stall}, 64'd0);
    check("flush.no_ready_busy", 64'(rdy_cnt), 64'd0);
    run_div("divu_9_3", C_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    alucontrolE = C_DIVU; a = 32'd100; b = 32'd7;
    repeat (5) @(negedge clk);
    #1;
    resetn = 1'b0;
    alucontrolE = C_NOP;
    #1;
    check("midrst.result", div_result, 64'd0);
    check("midrst.ready", {63'd0, div_ready}, 64'd0);
    check("midrst.stall", {63'd0, div_stall}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (div_ready) rdy_cnt++;
    end
    check("midrst.no_ready", 64'(rdy_cnt), 64'd0);
    check("midrst.result_kept", div_result, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
